// File: rtl/gem_cluster_pkg.sv
// Shared cluster constants, types and FSM encoding for the 1536-strip cluster pack/unpack path.
// Address values at or above MXSTRIPS mark an empty cluster slot.
package gem_cluster_pkg;
    localparam int MXADRBITS = 11;
    localparam int MXCNTBITS = 3;
    localparam int MXSTRIPS  = 1536;
    localparam int NCLUSTERS = 8;

    localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF;
    localparam int HALF_STRIPS = 768;

    typedef logic [MXADRBITS-1:0] cluster_adr_t;
    typedef logic [MXCNTBITS-1:0] cluster_cnt_t;
    // One extra bit so adr+cnt past 2047 does not wrap
    typedef logic [MXADRBITS:0]   span_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic adr_valid(input cluster_adr_t adr);
        return adr < cluster_adr_t'(MXSTRIPS);
    endfunction
endpackage

// File: rtl/cluster_unpacker_if.sv
// Frame-level bus between a cluster source and the unpacker: packed clusters in, hit map out.
// overlap_err exists only when CLUSTER_UNPACKER_OVERLAP_CHECK_EN is defined.
interface cluster_unpacker_if;
    import gem_cluster_pkg::*;

    logic                            latch_in;
    logic [NCLUSTERS*MXADRBITS-1:0]  adr_in;
    logic [NCLUSTERS*MXCNTBITS-1:0]  cnt_in;
    logic                            busy;
    logic [MXSTRIPS-1:0]             vpfs_out;
    logic                            vpfs_valid;
    logic [3:0]                      n_clusters;
    logic                            overrun;
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
    logic                            overlap_err;
`endif

    modport master (
        output latch_in, adr_in, cnt_in,
        input  busy, vpfs_out, vpfs_valid, n_clusters, overrun
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
        , input overlap_err
`endif
    );

    modport slave (
        input  latch_in, adr_in, cnt_in,
        output busy, vpfs_out, vpfs_valid, n_clusters, overrun
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
        , output overlap_err
`endif
    );
endinterface

// File: rtl/cluster_mask_gen.sv
// Combinational span mask: bits adr..adr+cnt set, clipped at the top strip, empty for adr >= MXSTRIPS.
// Zero latency; no flow control.
module cluster_mask_gen
    import gem_cluster_pkg::*;
(
    input  cluster_adr_t        adr,
    input  cluster_cnt_t        cnt,
    output logic [MXSTRIPS-1:0] mask
);
    span_t lo;
    span_t hi;

    assign lo = span_t'(adr);
    assign hi = lo + span_t'(cnt);

    // Only strips below MXSTRIPS exist, so clipping falls out of the bit range
    for (genvar g = 0; g < MXSTRIPS; g++) begin : g_bit
        assign mask[g] = (lo <= span_t'(g)) && (span_t'(g) <= hi);
    end
endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the 1536-strip hit map from 8 packed clusters, one per clock; CLUSTER_UNPACKER_OVERLAP_CHECK_EN adds overlap_err.
// Latency 9 clocks latch->vpfs_valid; no backpressure: a latch while busy is dropped and flagged on overrun.
module cluster_unpacker
    import gem_cluster_pkg::*;
(
    input  logic              clock4x,
    input  logic              global_reset,
    cluster_unpacker_if.slave bus
);
    localparam logic [2:0] IDX_LAST = 3'(NCLUSTERS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          idx;
    cluster_adr_t        adr_q [NCLUSTERS];
    cluster_cnt_t        cnt_q [NCLUSTERS];
    logic [MXSTRIPS-1:0] work_map;
    logic [MXSTRIPS-1:0] mask;
    logic [MXSTRIPS-1:0] vpfs_q;
    logic [3:0]          vld_cnt;
    logic [3:0]          n_clusters_q;
    logic                vpfs_valid_q;
    logic                overrun_pend;
    logic                overrun_q;

    cluster_mask_gen u_mask_gen (
        .adr  (adr_q[idx]),
        .cnt  (cnt_q[idx]),
        .mask (mask)
    );

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.latch_in) state_nxt = EXPAND;
            EXPAND:  if (idx == IDX_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            idx          <= '0;
            work_map     <= '0;
            vld_cnt      <= '0;
            vpfs_q       <= '0;
            n_clusters_q <= '0;
            vpfs_valid_q <= 1'b0;
            overrun_pend <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < NCLUSTERS; k++) begin
                adr_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            vpfs_valid_q <= 1'b0;
            // Dropped latch is reported one edge after it was sampled
            overrun_pend <= bus.latch_in && (state != IDLE);
            overrun_q    <= overrun_pend;
            case (state)
                IDLE: begin
                    if (bus.latch_in) begin
                        for (int k = 0; k < NCLUSTERS; k++) begin
                            adr_q[k] <= bus.adr_in[k*MXADRBITS +: MXADRBITS];
                            cnt_q[k] <= bus.cnt_in[k*MXCNTBITS +: MXCNTBITS];
                        end
                        work_map <= '0;
                        vld_cnt  <= '0;
                        idx      <= '0;
                    end
                end
                EXPAND: begin
                    work_map <= work_map | mask;
                    if (adr_valid(adr_q[idx])) vld_cnt <= vld_cnt + 4'd1;
                    idx <= idx + 3'd1;
                end
                DONE: begin
                    vpfs_q       <= work_map;
                    n_clusters_q <= vld_cnt;
                    vpfs_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.vpfs_out   = vpfs_q;
    assign bus.vpfs_valid = vpfs_valid_q;
    assign bus.n_clusters = n_clusters_q;
    assign bus.overrun    = overrun_q;

`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
    logic ovl_acc;
    logic ovl_q;

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            ovl_acc <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (bus.latch_in) ovl_acc <= 1'b0;
                EXPAND:  ovl_acc <= ovl_acc | (|(mask & work_map));
                DONE:    ovl_q   <= ovl_acc;
                default: ;
            endcase
        end
    end

    assign bus.overlap_err = ovl_q;
`endif
endmodule
